// File: rtl/rv32i_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding word reads, and
// presents each fetched word to the decoder for one cycle (NOP bubble otherwise).
module rv32i_fetch #(
   parameter logic [31:0] RV32I_RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] RV32I_NOP          = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        update_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   output logic [31:0] imem_addr,
   output logic        imem_read,
   input  logic        imem_waitrequest,
   input  logic [31:0] imem_readdata,
   input  logic        imem_readdatavalid
);

   // Bit 0 is set only in S_REQ so imem_read comes straight off a state flop.
   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_REQ   = 3'b001,
      S_WAIT  = 3'b010,
      S_HOLD  = 3'b100,
      S_FLUSH = 3'b110
   } state_t;

   state_t      state_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        valid_q;
   logic [31:0] buf_instr_q;
   logic [31:0] buf_pc_q;

   logic [31:0] target_pc_d;
   logic [31:0] fetch_pc_inc_d;
   logic        req_accepted;
   logic        unused_addr_lsbs;

   assign target_pc_d      = {branch_addr[31:2], 2'b00};
   assign fetch_pc_inc_d   = fetch_pc_q + 32'd4;
   assign req_accepted     = (state_q == S_REQ) && !imem_waitrequest;
   assign unused_addr_lsbs = ^branch_addr[1:0];

   assign update_pc   = branch_taken;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign instr_valid = valid_q;
   assign imem_read   = state_q[0];
   assign imem_addr   = fetch_pc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RV32I_RESET_VECTOR;
         instr_q     <= RV32I_NOP;
         pc_q        <= RV32I_RESET_VECTOR;
         valid_q     <= 1'b0;
         buf_instr_q <= RV32I_NOP;
         buf_pc_q    <= RV32I_RESET_VECTOR;
      end else if (branch_taken) begin
         // Redirect beats stall and returning data; any in-flight read becomes stale.
         fetch_pc_q <= target_pc_d;
         instr_q    <= RV32I_NOP;
         valid_q    <= 1'b0;
         case (state_q)
            S_REQ:           state_q <= req_accepted ? S_FLUSH : S_REQ;
            S_WAIT, S_FLUSH: state_q <= imem_readdatavalid ? S_REQ : S_FLUSH;
            default:         state_q <= S_REQ;
         endcase
      end else begin
         if (!stall) begin
            instr_q <= RV32I_NOP;
            valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: state_q <= S_REQ;
            S_REQ: begin
               if (!imem_waitrequest) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_readdatavalid) begin
                  fetch_pc_q <= fetch_pc_inc_d;
                  if (stall) begin
                     buf_instr_q <= imem_readdata;
                     buf_pc_q    <= fetch_pc_q;
                     state_q     <= S_HOLD;
                  end else begin
                     instr_q <= imem_readdata;
                     pc_q    <= fetch_pc_q;
                     valid_q <= 1'b1;
                     state_q <= S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instr_q <= buf_instr_q;
                  pc_q    <= buf_pc_q;
                  valid_q <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_FLUSH: begin
               if (imem_readdatavalid) state_q <= S_REQ;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   a_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
      imem_read && imem_waitrequest && !branch_taken |=> imem_read && $stable(imem_addr));
   a_valid_pulse: assert property (@(posedge clk) disable iff (!reset_n)
      instr_valid && !stall |=> !instr_valid);
   a_addr_aligned: assert property (@(posedge clk) disable iff (!reset_n)
      imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch with a small latency/waitrequest-controllable memory model.
module tb_rv32i_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = 32'h0;
   logic        update_pc;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic [31:0] imem_addr;
   logic        imem_read;
   logic        imem_waitrequest = 1'b0;
   logic [31:0] imem_readdata = 32'h0;
   logic        imem_readdatavalid = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   int          lat = 1;
   int          cnt = 0;
   bit          pend = 1'b0;
   logic [31:0] paddr = 32'h0;
   logic [31:0] wr_addr = 32'hFFFF_FFFF;
   int          wr_left = 0;
   int          acc4 = 0;

   always #5 clk = ~clk;

   rv32i_fetch dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .stall              (stall),
      .branch_taken       (branch_taken),
      .branch_addr        (branch_addr),
      .update_pc          (update_pc),
      .instr              (instr),
      .pc                 (pc),
      .instr_valid        (instr_valid),
      .imem_addr          (imem_addr),
      .imem_read          (imem_read),
      .imem_waitrequest   (imem_waitrequest),
      .imem_readdata      (imem_readdata),
      .imem_readdatavalid (imem_readdatavalid)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5EED_0003;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic chk_out(input string t, input bit v, input logic [31:0] p);
      check({t, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
      if (v) begin
         check({t, ".pc"}, pc, p);
         check({t, ".instr"}, instr, mem_word(p));
      end else begin
         check({t, ".instr"}, instr, NOP);
      end
   endtask

   task automatic chk_rd(input string t, input bit r, input logic [31:0] a);
      check({t, ".read"}, {31'd0, imem_read}, {31'd0, r});
      if (r) check({t, ".addr"}, imem_addr, a);
   endtask

   // One clock of the memory model; leaves time at edge+1.
   task automatic tick();
      bit          acc;
      logic [31:0] aa;
      acc = reset_n && imem_read && !imem_waitrequest;
      aa  = imem_addr;
      @(posedge clk);
      #1;
      imem_readdatavalid = 1'b0;
      if (acc) begin
         pend  = 1'b1;
         paddr = aa;
         cnt   = lat;
         if (aa == 32'h4) acc4++;
      end
      if (pend) begin
         if (cnt <= 1) begin
            imem_readdatavalid = 1'b1;
            imem_readdata      = mem_word(paddr);
            pend               = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_waitrequest = 1'b0;
      if (imem_read && imem_addr == wr_addr && wr_left > 0) begin
         imem_waitrequest = 1'b1;
         wr_left--;
      end
   endtask

   task automatic do_reset();
      reset_n            = 1'b0;
      stall              = 1'b0;
      branch_taken       = 1'b0;
      pend               = 1'b0;
      imem_readdatavalid = 1'b0;
      imem_waitrequest   = 1'b0;
      wr_left            = 0;
      lat                = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #2;
      chk_out("rst", 0, 0);
      check("rst.pc", pc, 32'h0);
      chk_rd("rst", 0, 0);
      check("rst.addr", imem_addr, 32'h0);
      check("rst.upd", {31'd0, update_pc}, 32'd0);

      // 1: zero-wait memory, one instruction every two cycles
      do_reset();
      for (int k = 0; k < 7; k++) begin
         tick();
         chk_rd($sformatf("t1.k%0d", k), (k % 2) == 0, 32'(2 * k));
         chk_out($sformatf("t1.k%0d", k), (k % 2) == 0 && k > 0, 32'(2 * k - 4));
      end

      // 2: waitrequest 3 cycles on 0x4
      do_reset();
      wr_addr = 32'h4; wr_left = 3; acc4 = 0;
      tick();
      for (int k = 1; k < 8; k++) begin
         tick();
         if (k >= 2 && k <= 5) chk_rd($sformatf("t2.k%0d", k), 1, 32'h4);
         if (k == 6) chk_rd("t2.k6", 0, 0);
         if (k == 3 || k == 5) chk_out($sformatf("t2.k%0d", k), 0, 0);
      end
      chk_out("t2.k7", 1, 32'h4);
      check("t2.reads4", acc4, 1);
      wr_addr = 32'hFFFF_FFFF;

      // 3: redirect in WAIT before data -> FLUSH
      do_reset();
      lat = 3;
      tick(); tick();
      chk_rd("t3.wait", 0, 0);
      branch_taken = 1'b1; branch_addr = 32'h103;
      #1 check("t3.upd1", {31'd0, update_pc}, 32'd1);
      tick();
      branch_taken = 1'b0;
      #1 check("t3.upd0", {31'd0, update_pc}, 32'd0);
      chk_out("t3.e2", 0, 0); chk_rd("t3.e2", 0, 0);
      lat = 1;
      tick(); chk_out("t3.e3", 0, 0); chk_rd("t3.e3", 0, 0);
      tick(); chk_out("t3.e4", 0, 0); chk_rd("t3.e4", 1, 32'h100);
      tick(); chk_out("t3.e5", 0, 0);
      tick(); chk_out("t3.e6", 1, 32'h100); chk_rd("t3.e6", 1, 32'h104);

      // 4: stall while word for 0x8 returns
      do_reset();
      for (int k = 0; k < 6; k++) tick();
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_out($sformatf("t4.s%0d", k), 0, 0);
         check($sformatf("t4.s%0d.pc", k), pc, 32'h4);
         chk_rd($sformatf("t4.s%0d", k), 0, 0);
      end
      stall = 1'b0;
      tick(); chk_out("t4.rel", 1, 32'h8); chk_rd("t4.rel", 1, 32'hC);
      tick(); chk_out("t4.after", 0, 0);

      // 5: redirect while holding a buffered word under stall
      do_reset();
      for (int k = 0; k < 5; k++) tick();
      stall = 1'b1;
      tick(); chk_out("t5.e5", 1, 32'h4);
      tick(); chk_out("t5.e6", 1, 32'h4); chk_rd("t5.e6", 0, 0);
      tick();
      branch_taken = 1'b1; branch_addr = 32'h200;
      tick();
      branch_taken = 1'b0;
      chk_out("t5.br", 0, 0); chk_rd("t5.br", 1, 32'h200);
      tick(); tick();
      chk_out("t5.e10", 0, 0);
      stall = 1'b0;
      tick(); chk_out("t5.e11", 1, 32'h200); chk_rd("t5.e11", 1, 32'h204);

      // 6a: redirect to top of memory with accepted request; PC wraps
      do_reset();
      tick(); tick(); tick();
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      chk_rd("t6.e3", 0, 0); chk_out("t6.e3", 0, 0);
      tick(); chk_rd("t6.e4", 1, 32'hFFFF_FFFC); chk_out("t6.e4", 0, 0);
      tick();
      tick(); chk_out("t6.e6", 1, 32'hFFFF_FFFC); chk_rd("t6.e6", 1, 32'h0);

      // 7: redirect while request is held off by waitrequest
      do_reset();
      wr_addr = 32'h4; wr_left = 10; acc4 = 0;
      tick(); tick(); tick(); tick();
      branch_taken = 1'b1; branch_addr = 32'h40;
      tick();
      branch_taken = 1'b0; wr_left = 0;
      chk_rd("t7.retarget", 1, 32'h40);
      tick();
      tick(); chk_out("t7.e6", 1, 32'h40);
      check("t7.reads4", acc4, 0);
      wr_addr = 32'hFFFF_FFFF;

      // 6b: reset mid-WAIT, late response ignored
      do_reset();
      for (int k = 0; k < 5; k++) tick();
      lat = 3;
      tick(); tick();
      reset_n = 1'b0;
      #1;
      chk_out("t8.rst", 0, 0);
      check("t8.rst.pc", pc, 32'h0);
      chk_rd("t8.rst", 0, 0);
      check("t8.rst.addr", imem_addr, 32'h0);
      tick();
      check("t8.late_rdv", {31'd0, imem_readdatavalid}, 32'd1);
      reset_n = 1'b1;
      lat = 1;
      tick(); chk_out("t8.e8", 0, 0); chk_rd("t8.e8", 1, 32'h0);
      tick(); chk_out("t8.e9", 0, 0);
      tick(); chk_out("t8.e10", 1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
